// File: rtl/loss_if.sv
// Valid/ready bundle for the loss stage: result in, target in, error delta out, inference result out.
// master = upstream/downstream environment side, slave = loss stage side.
interface loss_if;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready;
  logic        tgt_valid;
  logic [15:0] tgt_data;
  logic        tgt_ready;
  logic        err_valid;
  logic [15:0] err_data;
  logic        err_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (
    output res_valid, res_data, tgt_valid, tgt_data, err_ready, out_ready,
    input  res_ready, tgt_ready, err_valid, err_data, out_valid, out_data
  );

  modport slave (
    input  res_valid, res_data, tgt_valid, tgt_data, err_ready, out_ready,
    output res_ready, tgt_ready, err_valid, err_data, out_valid, out_data
  );
endinterface

// File: rtl/loss.sv
// Terminal error stage: returns saturated (target - result) in training, passes results out in inference.
// One sample in flight; res/tgt ready only in their own states, err/out hold until accepted.
module loss #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             train,
  loss_if.slave            bus,
  output logic [ACC_W-1:0] loss_data,
  output logic [CNT_W-1:0] loss_count
);

  typedef enum logic [2:0] {
    RES = 3'd0,
    TGT = 3'd1,
    DIF = 3'd2,
    ERR = 3'd3,
    OUT = 3'd4
  } state_t;

  state_t           state_q;
  logic [15:0]      res_q;
  logic [15:0]      tgt_q;
  logic [15:0]      err_q;
  logic [15:0]      out_q;
  logic             err_vld_q;
  logic             out_vld_q;
  logic [ACC_W-1:0] loss_q;
  logic [CNT_W-1:0] cnt_q;

  logic [16:0]      diff;
  logic [15:0]      err_d;
  logic [16:0]      abs_err;
  logic [ACC_W:0]   loss_sum;
  logic [ACC_W-1:0] loss_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    diff  = {tgt_q[15], tgt_q} - {res_q[15], res_q};
    err_d = diff[15:0];
    // Bits 16 and 15 disagree only when the difference left the Q8.8 range.
    if (diff[16] != diff[15]) begin
      err_d = diff[16] ? 16'h8000 : 16'h7FFF;
    end
    abs_err  = err_q[15] ? (17'd0 - {1'b1, err_q}) : {1'b0, err_q};
    loss_sum = {1'b0, loss_q} + {{(ACC_W-16){1'b0}}, abs_err};
    loss_d   = loss_sum[ACC_W] ? {ACC_W{1'b1}} : loss_sum[ACC_W-1:0];
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RES;
      res_q     <= '0;
      tgt_q     <= '0;
      err_q     <= '0;
      out_q     <= '0;
      err_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      loss_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        RES: begin
          // The chosen next state is the mode latch; later train changes are ignored.
          if (bus.res_valid) begin
            res_q   <= bus.res_data;
            state_q <= train ? TGT : OUT;
          end
        end
        TGT: begin
          if (bus.tgt_valid) begin
            tgt_q   <= bus.tgt_data;
            state_q <= DIF;
          end
        end
        DIF: begin
          err_q     <= err_d;
          err_vld_q <= 1'b1;
          state_q   <= ERR;
        end
        ERR: begin
          if (bus.err_ready) begin
            err_vld_q <= 1'b0;
            loss_q    <= loss_d;
            cnt_q     <= cnt_d;
            state_q   <= RES;
          end
        end
        OUT: begin
          if (!out_vld_q) begin
            out_vld_q <= 1'b1;
            out_q     <= res_q;
          end else if (bus.out_ready) begin
            out_vld_q <= 1'b0;
            state_q   <= RES;
          end
        end
        default: begin
          state_q   <= RES;
          err_vld_q <= 1'b0;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_ready = (state_q == RES);
  assign bus.tgt_ready = (state_q == TGT);
  assign bus.err_valid = err_vld_q;
  assign bus.err_data  = err_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_q;
  assign loss_data     = loss_q;
  assign loss_count    = cnt_q;

endmodule

// File: tb/tb_loss.sv
// Directed bench for the loss stage: reset, inference, training, saturation, backpressure, mode latch, mid-sample reset.
module tb_loss;
  logic        clock;
  logic        reset;
  logic        train;
  logic [31:0] loss_data;
  logic [15:0] loss_count;
  int          tests;
  int          fails;

  loss_if bus ();

  loss #(.ACC_W(32), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .train      (train),
    .bus        (bus.slave),
    .loss_data  (loss_data),
    .loss_count (loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_res(input logic [15:0] d, input logic tr);
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    train         = tr;
    step();
    bus.res_valid = 1'b0;
    bus.res_data  = 16'h0000;
  endtask

  task automatic send_tgt(input logic [15:0] d);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = d;
    step();
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests++; if (bus.res_ready !== 1'b1) begin fails++; $display("FAIL rst_res_ready: got %b want 1", bus.res_ready); end
    tests++; if (bus.tgt_ready !== 1'b0) begin fails++; $display("FAIL rst_tgt_ready: got %b want 0", bus.tgt_ready); end
    tests++; if (bus.err_valid !== 1'b0 || bus.err_data !== 16'h0000) begin fails++; $display("FAIL rst_err: got %b/%h want 0/0000", bus.err_valid, bus.err_data); end
    tests++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000) begin fails++; $display("FAIL rst_out: got %b/%h want 0/0000", bus.out_valid, bus.out_data); end
    tests++; if (loss_data !== 32'd0 || loss_count !== 16'd0) begin fails++; $display("FAIL rst_stats: got %h/%0d want 0/0", loss_data, loss_count); end
  endtask

  task automatic test_inference();
    send_res(16'h0180, 1'b0);
    tests++; if (bus.res_ready !== 1'b0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL inf_t1: got rdy=%b ov=%b want 0/0", bus.res_ready, bus.out_valid); end
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0180) begin fails++; $display("FAIL inf_out: got %b/%h want 1/0180", bus.out_valid, bus.out_data); end
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0180 || bus.tgt_ready !== 1'b0 || bus.err_valid !== 1'b0) begin
      fails++; $display("FAIL inf_hold: got ov=%b od=%h tr=%b ev=%b want 1/0180/0/0", bus.out_valid, bus.out_data, bus.tgt_ready, bus.err_valid);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.res_ready !== 1'b1 || loss_count !== 16'd0) begin
      fails++; $display("FAIL inf_done: got ov=%b rr=%b cnt=%0d want 0/1/0", bus.out_valid, bus.res_ready, loss_count);
    end
  endtask

  task automatic test_training_basic();
    send_res(16'h0100, 1'b1);
    tests++; if (bus.tgt_ready !== 1'b1) begin fails++; $display("FAIL trn_tgt_ready: got %b want 1", bus.tgt_ready); end
    send_tgt(16'h0300);
    tests++; if (bus.err_valid !== 1'b0) begin fails++; $display("FAIL trn_dif: got err_valid %b want 0", bus.err_valid); end
    step();
    tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 16'h0200) begin fails++; $display("FAIL trn_err: got %b/%h want 1/0200", bus.err_valid, bus.err_data); end
    bus.err_ready = 1'b1;
    step();
    bus.err_ready = 1'b0;
    tests++; if (bus.err_valid !== 1'b0 || loss_data !== 32'h200 || loss_count !== 16'd1) begin
      fails++; $display("FAIL trn_stats: got ev=%b loss=%h cnt=%0d want 0/200/1", bus.err_valid, loss_data, loss_count);
    end
  endtask

  task automatic test_saturation();
    send_res(16'h8000, 1'b1);
    send_tgt(16'h7FFF);
    step();
    tests++; if (bus.err_data !== 16'h7FFF) begin fails++; $display("FAIL sat_pos: got %h want 7fff", bus.err_data); end
    bus.err_ready = 1'b1;
    step();
    bus.err_ready = 1'b0;
    tests++; if (loss_data !== 32'h81FF || loss_count !== 16'd2) begin fails++; $display("FAIL sat_pos_stats: got %h/%0d want 81ff/2", loss_data, loss_count); end
    send_res(16'h7FFF, 1'b1);
    send_tgt(16'h8000);
    step();
    tests++; if (bus.err_data !== 16'h8000) begin fails++; $display("FAIL sat_neg: got %h want 8000", bus.err_data); end
    bus.err_ready = 1'b1;
    step();
    bus.err_ready = 1'b0;
    tests++; if (loss_data !== 32'h101FF || loss_count !== 16'd3) begin fails++; $display("FAIL sat_neg_stats: got %h/%0d want 101ff/3", loss_data, loss_count); end
  endtask

  task automatic test_backpressure();
    send_res(16'h0010, 1'b1);
    send_tgt(16'h0008);
    step();
    // A stray target while in ERR must be refused and leave the delta untouched.
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 16'hFFF8 || bus.res_ready !== 1'b0 || bus.tgt_ready !== 1'b0 ||
                   loss_data !== 32'h101FF || loss_count !== 16'd3) begin
        fails++; $display("FAIL bp_hold[%0d]: got ev=%b ed=%h rr=%b tr=%b loss=%h cnt=%0d want 1/fff8/0/0/101ff/3",
                          i, bus.err_valid, bus.err_data, bus.res_ready, bus.tgt_ready, loss_data, loss_count);
      end
      step();
    end
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = 16'h0000;
    bus.err_ready = 1'b1;
    step();
    bus.err_ready = 1'b0;
    tests++; if (bus.err_valid !== 1'b0 || loss_data !== 32'h10207 || loss_count !== 16'd4) begin
      fails++; $display("FAIL bp_done: got ev=%b loss=%h cnt=%0d want 0/10207/4", bus.err_valid, loss_data, loss_count);
    end
  endtask

  task automatic test_mode_latch();
    send_res(16'h0200, 1'b1);
    train = 1'b0;
    step();
    step();
    tests++; if (bus.tgt_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL ml_wait: got tr=%b ov=%b want 1/0", bus.tgt_ready, bus.out_valid); end
    send_tgt(16'h0100);
    step();
    tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 16'hFF00) begin fails++; $display("FAIL ml_err: got %b/%h want 1/ff00", bus.err_valid, bus.err_data); end
    bus.err_ready = 1'b1;
    step();
    bus.err_ready = 1'b0;
    tests++; if (loss_data !== 32'h10307 || loss_count !== 16'd5) begin fails++; $display("FAIL ml_stats: got %h/%0d want 10307/5", loss_data, loss_count); end
    send_res(16'h0055, 1'b0);
    tests++; if (bus.tgt_ready !== 1'b0) begin fails++; $display("FAIL ml_next_mode: got tgt_ready %b want 0", bus.tgt_ready); end
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0055) begin fails++; $display("FAIL ml_next_out: got %b/%h want 1/0055", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests++; if (bus.res_ready !== 1'b1 || loss_count !== 16'd5) begin fails++; $display("FAIL ml_next_done: got rr=%b cnt=%0d want 1/5", bus.res_ready, loss_count); end
  endtask

  task automatic test_reset_in_err();
    send_res(16'h0000, 1'b1);
    send_tgt(16'h0001);
    step();
    tests++; if (bus.err_valid !== 1'b1 || bus.err_data !== 16'h0001) begin fails++; $display("FAIL rerr_pre: got %b/%h want 1/0001", bus.err_valid, bus.err_data); end
    bus.err_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.err_ready = 1'b0;
    tests++; if (bus.err_valid !== 1'b0 || loss_data !== 32'd0 || loss_count !== 16'd0 || bus.res_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL rerr_post: got ev=%b loss=%h cnt=%0d rr=%b ov=%b want 0/0/0/1/0",
                        bus.err_valid, loss_data, loss_count, bus.res_ready, bus.out_valid);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    train         = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = 16'h0000;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = 16'h0000;
    bus.err_ready = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_inference();
    test_training_basic();
    test_saturation();
    test_backpressure();
    test_mode_latch();
    test_reset_in_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
